// File: rtl/stream_mux_rr_if.sv
// Stream bundle between N producers, the round-robin mux and one consumer.
// The slave modport is the mux's view; the master modport is the
// producer/consumer side that drives the inputs and observes the outputs.
interface stream_mux_rr_if #(
    parameter int N     = 2,
    parameter int W     = 8,
    parameter int SEL_W = 1
);
    logic [N*W-1:0]   in_data;
    logic [N-1:0]     in_valid;
    logic [N-1:0]     in_last;
    logic [N-1:0]     in_ready;
    logic [W-1:0]     out_data;
    logic             out_valid;
    logic             out_last;
    logic [SEL_W-1:0] out_sel;
    logic             out_ready;

    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_valid, out_last, out_sel
    );

    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_valid, out_last, out_sel
    );
endinterface

// File: rtl/stream_mux_rr.sv
// N-to-1 registered stream mux with packet-granular round-robin arbitration.
// A channel is granted in IDLE, then owns the output until its in_last beat
// is accepted; the output stage is a single register slice that can refill
// on the same edge it drains, so a packet streams at one beat per clock.
//
//   state | meaning
//   IDLE  | no grant held; arbitrate among valid channels (no beat accepted)
//   LOCK  | grant held; only the granted channel may transfer beats
module stream_mux_rr #(
    parameter int N     = 2,
    parameter int W     = 8,
    parameter int SEL_W = 1
) (
    input  logic             clk,
    input  logic             rst,
    stream_mux_rr_if.slave   bus,
    output logic             busy
);

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [SEL_W-1:0] grant_q;
    logic [SEL_W-1:0] grant_d;
    logic [SEL_W-1:0] last_grant_q;
    logic [SEL_W-1:0] pick;
    logic             pick_found;
    logic [W-1:0]     sel_data;
    logic             sel_valid;
    logic             sel_last;
    logic [N-1:0]     ready_vec;
    logic             can_load;
    logic             accept;
    logic             pkt_end;

    // Round-robin pick: first valid channel after last_grant, wrapping at N-1.
    always_comb begin
        pick       = '0;
        pick_found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!pick_found && (i == (int'(last_grant_q) + k) % N) && bus.in_valid[i]) begin
                    pick       = SEL_W'(i);
                    pick_found = 1'b1;
                end
            end
        end
    end

    // Route the granted channel's beat towards the output register.
    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (grant_q == SEL_W'(i)) begin
                sel_data  = bus.in_data[i*W +: W];
                sel_valid = bus.in_valid[i];
                sel_last  = bus.in_last[i];
            end
        end
    end

    // The output slice can take a beat when empty or draining this cycle.
    assign can_load = !bus.out_valid || bus.out_ready;
    assign accept   = (state_q == LOCK) && sel_valid && can_load;
    assign pkt_end  = accept && sel_last;

    // Only the granted channel sees ready, and only while holding the grant.
    always_comb begin
        ready_vec = '0;
        if (state_q == LOCK) begin
            for (int i = 0; i < N; i++) begin
                if (grant_q == SEL_W'(i)) begin
                    ready_vec[i] = can_load;
                end
            end
        end
    end

    assign bus.in_ready = ready_vec;
    assign busy         = (state_q == LOCK);

    // Next-state: grab a grant in IDLE, release it after the last beat.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_d = pick;
                    state_d = LOCK;
                end
            end
            LOCK: begin
                if (pkt_end) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, grant and rotation pointer; reset points the rotation at N-1 so
    // the first arbitration after reset starts scanning at channel 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= SEL_W'(N - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            if (pkt_end) begin
                last_grant_q <= grant_q;
            end
        end
    end

    // Output register slice: load on accept, clear valid when drained empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
            bus.out_data  <= '0;
            bus.out_sel   <= '0;
        end else if (accept) begin
            bus.out_valid <= 1'b1;
            bus.out_last  <= sel_last;
            bus.out_data  <= sel_data;
            bus.out_sel   <= grant_q;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end

endmodule
